sd_card_dat_responder: RTL and testbench

Card-side DAT-line engine for the SD host bench and card model. It is the opposite end of the host DAT communication path.
- On a write, it receives data blocks from the host on DAT: start bit, payload, per-lane CRC16, end bit. It unpacks them into 32-bit words and answers with a CRC status token and a busy period.
- On a read, it fetches 32-bit words and transmits a framed block back to the host.
- It supports 1-bit and 4-bit bus widths, single block per command.

---
 rtl/sd_card_dat_responder.sv | 248 ++++++++++++++++++++++++
 tb/tb_sd_card_dat_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_card_dat_responder.sv
// Card-side SD DAT engine: receives host write blocks (CRC16 check, status token, busy)
// and transmits read blocks, in 1-bit or 4-bit bus mode, one block per command.
module sd_card_dat_responder #(
  parameter int unsigned block_size  = 512,
  parameter int unsigned busy_cycles = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wide_bus,
  input  logic        write_start,
  input  logic        read_start,
  input  logic [3:0]  dat_i,
  output logic [3:0]  dat_o,
  output logic [3:0]  dat_oe,
  input  logic [31:0] rd_word,
  output logic        rd_word_req,
  output logic [31:0] wr_word,
  output logic        wr_word_valid,
  output logic        crc_ok,
  output logic        busy,
  output logic        done
);
  localparam int unsigned Words  = block_size / 4;
  localparam int unsigned WordW  = $clog2(Words + 1);
  localparam int unsigned CntMax = (busy_cycles > 16) ? busy_cycles : 16;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [WordW-1:0] LastWord   = WordW'(Words - 1);
  localparam logic [WordW-1:0] PenultWord = WordW'(Words - 2);
  localparam logic [CntW-1:0]  BusyLast   = CntW'(busy_cycles - 1);

  typedef enum logic [3:0] {
    StIdle, StRxStart, StRxData, StRxCrc, StRxEnd, StTkGap, StToken, StBusy,
    StTxGap, StTxStart, StTxData, StTxCrc, StTxEnd
  } state_e;

  state_e            state_q, state_d;
  logic              wide_q, wide_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [4:0]        bit_q, bit_d;
  logic [WordW-1:0]  word_q, word_d;
  logic [31:0]       sh_q, sh_d, hold_q, hold_d;
  logic [3:0][15:0]  crc_q, crc_d;
  logic              err_q, err_d, pend_q, pend_d;
  logic [31:0]       wr_word_q, wr_word_d;
  logic              wr_valid_q, wr_valid_d, crc_ok_q, crc_ok_d, done_q, done_d;

  logic [3:0]  act, prim, tx_bits;
  logic [31:0] rx_word;
  logic        last_bit, last_word;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  assign act       = wide_q ? 4'hF : 4'h8;
  assign prim      = wide_q ? 4'h1 : 4'h8;
  assign last_bit  = wide_q ? (bit_q == 5'd7) : (bit_q == 5'd31);
  assign last_word = (word_q == LastWord);
  assign rx_word   = wide_q ? {sh_q[27:0], dat_i} : {sh_q[30:0], dat_i[3]};
  assign tx_bits   = wide_q ? sh_q[31:28] : {sh_q[31], 3'b111};

  always_comb begin
    state_d     = state_q;
    wide_d      = wide_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    word_d      = word_q;
    sh_d        = sh_q;
    hold_d      = pend_q ? rd_word : hold_q;
    crc_d       = crc_q;
    err_d       = err_q;
    pend_d      = 1'b0;
    wr_word_d   = wr_word_q;
    wr_valid_d  = 1'b0;
    crc_ok_d    = crc_ok_q;
    done_d      = 1'b0;
    rd_word_req = 1'b0;
    dat_o       = 4'hF;
    dat_oe      = 4'h0;

    unique case (state_q)
      StIdle: begin
        if (write_start || read_start) begin
          wide_d = wide_bus;
          cnt_d  = '0;
          bit_d  = '0;
          word_d = '0;
          crc_d  = '0;
          err_d  = 1'b0;
          // Write has priority; a simultaneous read is dropped.
          if (write_start) begin
            state_d = StRxStart;
          end else begin
            state_d     = StTxGap;
            rd_word_req = 1'b1;
            pend_d      = 1'b1;
          end
        end
      end
      StRxStart: if ((dat_i & act) == 4'h0) state_d = StRxData;
      StRxData: begin
        for (int i = 0; i < 4; i++) if (act[i]) crc_d[i] = crc_step(crc_q[i], dat_i[i]);
        sh_d  = rx_word;
        bit_d = bit_q + 5'd1;
        if (last_bit) begin
          wr_word_d  = rx_word;
          wr_valid_d = 1'b1;
          bit_d      = '0;
          word_d     = word_q + 1'b1;
          if (last_word) state_d = StRxCrc;
        end
      end
      StRxCrc: begin
        for (int i = 0; i < 4; i++) begin
          if (act[i] && (dat_i[i] != crc_q[i][15])) err_d = 1'b1;
          crc_d[i] = {crc_q[i][14:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(15)) state_d = StRxEnd;
      end
      StRxEnd: begin
        if ((~dat_i & act) != 4'h0) err_d = 1'b1;
        cnt_d   = '0;
        state_d = StTkGap;
      end
      StTkGap: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(1)) begin
          cnt_d    = '0;
          state_d  = StToken;
          sh_d     = {(err_q ? 5'b01011 : 5'b00101), 27'd0};
          crc_ok_d = ~err_q;
        end
      end
      StToken: begin
        dat_oe = prim;
        dat_o  = sh_q[31] ? 4'hF : ~prim;
        sh_d   = {sh_q[30:0], 1'b0};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CntW'(4)) begin
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        dat_oe = prim;
        dat_o  = ~prim;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == BusyLast) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      StTxGap: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(1)) state_d = StTxStart;
      end
      StTxStart: begin
        dat_oe  = act;
        dat_o   = ~act;
        sh_d    = hold_q;
        state_d = StTxData;
        if (Words > 1) begin
          rd_word_req = 1'b1;
          pend_d      = 1'b1;
        end
      end
      StTxData: begin
        dat_oe = act;
        dat_o  = tx_bits;
        for (int i = 0; i < 4; i++) if (act[i]) crc_d[i] = crc_step(crc_q[i], tx_bits[i]);
        sh_d  = wide_q ? {sh_q[27:0], 4'h0} : {sh_q[30:0], 1'b0};
        bit_d = bit_q + 5'd1;
        if (last_bit) begin
          bit_d = '0;
          if (last_word) begin
            cnt_d   = '0;
            state_d = StTxCrc;
          end else begin
            sh_d   = hold_q;
            word_d = word_q + 1'b1;
            // The word just moved in is the last one; nothing left to prefetch.
            if (word_q != PenultWord) begin
              rd_word_req = 1'b1;
              pend_d      = 1'b1;
            end
          end
        end
      end
      StTxCrc: begin
        dat_oe = act;
        for (int i = 0; i < 4; i++) begin
          dat_o[i] = act[i] ? crc_q[i][15] : 1'b1;
          crc_d[i] = {crc_q[i][14:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(15)) state_d = StTxEnd;
      end
      StTxEnd: begin
        dat_oe  = act;
        state_d = StIdle;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      wide_q     <= 1'b0;
      cnt_q      <= '0;
      bit_q      <= '0;
      word_q     <= '0;
      sh_q       <= '0;
      hold_q     <= '0;
      crc_q      <= '0;
      err_q      <= 1'b0;
      pend_q     <= 1'b0;
      wr_word_q  <= '0;
      wr_valid_q <= 1'b0;
      crc_ok_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wide_q     <= wide_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      word_q     <= word_d;
      sh_q       <= sh_d;
      hold_q     <= hold_d;
      crc_q      <= crc_d;
      err_q      <= err_d;
      pend_q     <= pend_d;
      wr_word_q  <= wr_word_d;
      wr_valid_q <= wr_valid_d;
      crc_ok_q   <= crc_ok_d;
      done_q     <= done_d;
    end
  end

  assign wr_word       = wr_word_q;
  assign wr_word_valid = wr_valid_q;
  assign crc_ok        = crc_ok_q;
  assign done          = done_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_sd_card_dat_responder.sv
// Scoreboard bench for sd_card_dat_responder: host/source drivers push expected pin,
// word and completion events; a negedge monitor pops and compares them cycle-exactly.
module tb_sd_card_dat_responder;
  localparam int BlockSize  = 8;
  localparam int BusyCycles = 8;
  localparam int Words      = BlockSize / 4;

  logic        clk = 1'b0, rst_n = 1'b0, wide_bus = 1'b0;
  logic        write_start = 1'b0, read_start = 1'b0;
  logic [3:0]  dat_i = 4'hF;
  logic [3:0]  dat_o, dat_oe;
  logic [31:0] rd_word = 32'h0;
  logic [31:0] wr_word;
  logic        rd_word_req, wr_word_valid, crc_ok, busy, done;

  int   cyc = 0, n_cmp = 0, n_err = 0, req_cnt = 0;
  logic model_crc_ok = 1'b0;
  logic [31:0] pay [Words];
  logic [31:0] src_q [$];

  typedef struct { int cyc; logic [3:0] oe; logic [3:0] d; } pin_t;
  typedef struct { int cyc; logic [31:0] w; } wr_t;
  typedef struct { int cyc; logic ok; } done_t;
  typedef bit bitq_t [$];
  pin_t  pin_q [$];
  wr_t   wr_q [$];
  done_t done_q [$];
  pin_t  pe;
  wr_t   we;
  done_t de;

  sd_card_dat_responder #(.block_size(BlockSize), .busy_cycles(BusyCycles)) dut (
    .clk(clk), .reset(rst_n), .wide_bus(wide_bus), .write_start(write_start),
    .read_start(read_start), .dat_i(dat_i), .dat_o(dat_o), .dat_oe(dat_oe),
    .rd_word(rd_word), .rd_word_req(rd_word_req), .wr_word(wr_word),
    .wr_word_valid(wr_word_valid), .crc_ok(crc_ok), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Read-word source with one cycle of latency.
  always @(posedge clk)
    if (rst_n && rd_word_req) rd_word <= (src_q.size() > 0) ? src_q.pop_front() : 32'hBAD0BAD0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_word_req) req_cnt++;
      if (pin_q.size() > 0 && pin_q[0].cyc == cyc) begin
        pe = pin_q.pop_front();
        check($sformatf("pin@%0d", cyc), {dat_oe, dat_o}, {pe.oe, pe.d});
      end else if (dat_oe != 4'h0) check($sformatf("unexpected_oe@%0d", cyc), dat_oe, 0);
      if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
        we = wr_q.pop_front();
        check($sformatf("wr_word@%0d", cyc), {wr_word_valid, wr_word}, {1'b1, we.w});
      end else if (wr_word_valid) check($sformatf("unexpected_wr@%0d", cyc), wr_word_valid, 0);
      if (done_q.size() > 0 && done_q[0].cyc == cyc) begin
        de = done_q.pop_front();
        check($sformatf("done@%0d", cyc), {done, crc_ok, busy}, {1'b1, de.ok, 1'b0});
      end else if (done) check($sformatf("unexpected_done@%0d", cyc), done, 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bits carried by one lane, in transmission order.
  function automatic bitq_t get_lane(input logic wide, input int lane);
    bitq_t q;
    for (int k = 0; k < Words; k++) begin
      if (wide) for (int n = 0; n < 8; n++) q.push_back(pay[k][28 - 4 * n + lane]);
      else if (lane == 3) for (int b = 31; b >= 0; b--) q.push_back(pay[k][b]);
    end
    return q;
  endfunction

  // CRC as the remainder of M(x)*x^16 divided by the generator, by long division.
  function automatic logic [15:0] crc16_div(input bitq_t msg);
    bitq_t m;
    logic [16:0] g;
    logic [15:0] r;
    g = 17'h11021;
    m = msg;
    for (int k = 0; k < 16; k++) m.push_back(1'b0);
    for (int i = 0; i < msg.size(); i++)
      if (m[i]) for (int j = 0; j <= 16; j++) m[i + j] = m[i + j] ^ g[16 - j];
    for (int k = 0; k < 16; k++) r[15 - k] = m[msg.size() + k];
    return r;
  endfunction

  function automatic logic [3:0][15:0] calc_crcs(input logic wide);
    logic [3:0][15:0] c;
    for (int j = 0; j < 4; j++) c[j] = crc16_div(get_lane(wide, j));
    return c;
  endfunction

  task automatic check_reset_vals(input string name);
    check(name, {dat_o, dat_oe, wr_word, wr_word_valid, rd_word_req, crc_ok, busy, done},
          {4'hF, 4'h0, 32'h0, 5'b00000});
  endtask

  task automatic do_write(input logic wide, input int flip_lane, input logic bad_end,
                          input logic both, input logic rd_in_busy, input int abort_p);
    int cpw, np, s, e, req0;
    logic [3:0][15:0] lc;
    logic [3:0] prim;
    logic [4:0] tok;
    logic ok;
    cpw  = wide ? 8 : 32;
    np   = cpw * Words;
    prim = wide ? 4'h1 : 4'h8;
    lc   = calc_crcs(wide);
    if (flip_lane >= 0) lc[flip_lane] = lc[flip_lane] ^ (16'h1 << $urandom_range(0, 15));
    ok   = (flip_lane < 0) && !bad_end;
    req0 = req_cnt;
    step(); write_start = 1'b1; read_start = both; wide_bus = wide;
    step(); write_start = 1'b0; read_start = 1'b0;
    check("busy_rise", busy, 1);
    repeat ($urandom_range(0, 3)) step();
    step(); s = cyc;
    dat_i = wide ? 4'h0 : {1'b0, 3'($urandom)};
    for (int k = 0; k < Words; k++) wr_q.push_back(wr_t'{s + (k + 1) * cpw + 1, pay[k]});
    for (int p = 0; p < np; p++) begin
      step();
      if (p == abort_p) begin
        rst_n = 1'b0;
        dat_i = 4'hF;
        #1;
        check_reset_vals("abort_reset");
        pin_q.delete(); wr_q.delete(); done_q.delete(); src_q.delete();
        model_crc_ok = 1'b0;
        #1;
        rst_n = 1'b1;
        return;
      end
      dat_i = wide ? pay[p / 8][31 - 4 * (p % 8) -: 4] : {pay[p / 32][31 - (p % 32)], 3'($urandom)};
    end
    for (int i = 0; i < 16; i++) begin
      step();
      if (wide) for (int j = 0; j < 4; j++) dat_i[j] = lc[j][15 - i];
      else dat_i = {lc[3][15 - i], 3'($urandom)};
    end
    step(); e = cyc;
    if (bad_end) dat_i = wide ? (4'hF ^ (4'h1 << $urandom_range(0, 3))) : {1'b0, 3'($urandom)};
    else dat_i = wide ? 4'hF : {1'b1, 3'($urandom)};
    tok = ok ? 5'b00101 : 5'b01011;
    for (int i = 0; i < 5; i++) pin_q.push_back(pin_t'{e + 3 + i, prim, tok[4 - i] ? 4'hF : ~prim});
    for (int i = 0; i < BusyCycles; i++) pin_q.push_back(pin_t'{e + 8 + i, prim, ~prim});
    model_crc_ok = ok;
    done_q.push_back(done_t'{e + 8 + BusyCycles, ok});
    while (cyc < e + 9 + BusyCycles) begin
      step();
      dat_i = 4'hF;
      read_start = rd_in_busy && (cyc == e + 10);
    end
    read_start = 1'b0;
    check("write_no_req", req_cnt - req0, 0);
  endtask

  task automatic do_read(input logic wide);
    int np, c, req0;
    logic [3:0][15:0] lc;
    logic [3:0] act, d;
    np  = (wide ? 8 : 32) * Words;
    act = wide ? 4'hF : 4'h8;
    lc  = calc_crcs(wide);
    for (int k = 0; k < Words; k++) src_q.push_back(pay[k]);
    req0 = req_cnt;
    step(); read_start = 1'b1; wide_bus = wide; c = cyc;
    pin_q.push_back(pin_t'{c + 3, act, ~act});
    for (int p = 0; p < np; p++) begin
      d = wide ? pay[p / 8][31 - 4 * (p % 8) -: 4] : {pay[p / 32][31 - (p % 32)], 3'b111};
      pin_q.push_back(pin_t'{c + 4 + p, act, d});
    end
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 4; j++) d[j] = act[j] ? lc[j][15 - i] : 1'b1;
      pin_q.push_back(pin_t'{c + 4 + np + i, act, d});
    end
    pin_q.push_back(pin_t'{c + 20 + np, act, 4'hF});
    done_q.push_back(done_t'{c + 21 + np, model_crc_ok});
    step(); read_start = 1'b0;
    while (cyc < c + 22 + np) step();
    check("read_req_count", req_cnt - req0, Words);
  endtask

  task automatic rand_pay();
    for (int k = 0; k < Words; k++) pay[k] = $urandom;
  endtask

  initial begin
    logic w;
    int fl;
    repeat (2) step();
    check_reset_vals("reset_vals");
    rst_n = 1'b1;
    step();

    pay[0] = 32'h01234567;
    pay[1] = 32'h89ABCDEF;
    do_write(1'b1, -1, 1'b0, 1'b0, 1'b0, -1);
    check("crc_ok_good", crc_ok, 1);
    do_write(1'b1, 2, 1'b0, 1'b0, 1'b0, -1);
    check("crc_ok_bad", crc_ok, 0);

    pay[0] = 32'hDEADBEEF;
    pay[1] = 32'h00000000;
    do_read(1'b0);

    rand_pay();
    do_write(1'b1, -1, 1'b0, 1'b0, 1'b0, 5);
    rand_pay();
    do_write(1'b1, -1, 1'b0, 1'b0, 1'b0, -1);
    check("crc_ok_after_abort", crc_ok, 1);

    rand_pay();
    do_write(1'b0, -1, 1'b0, 1'b1, 1'b1, -1);

    for (int i = 0; i < 40; i++) begin
      step();
      dat_i = 4'($urandom);
    end
    step();
    dat_i = 4'hF;
    check("idle_quiet", {busy, dat_oe}, 0);

    for (int t = 0; t < 14; t++) begin
      rand_pay();
      w = 1'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        do_read(w);
      end else begin
        fl = ($urandom_range(0, 2) == 0) ? (w ? $urandom_range(0, 3) : 3) : -1;
        do_write(w, fl, ($urandom_range(0, 3) == 0), 1'b0, 1'b0, -1);
        check("crc_ok_rand", crc_ok, model_crc_ok);
      end
    end

    repeat (3) step();
    check("pin_q_drained", pin_q.size(), 0);
    check("wr_q_drained", wr_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
